// File: rtl/csr_commit_queue_if.sv
// Commit-side and sink-side handshake bundle for the CSR/exception commit queue.
interface csr_commit_queue_if #(
  parameter int LANES = 2,
  parameter int XLEN  = 32
);
  logic [LANES-1:0]      in_valid;
  logic [LANES-1:0]      in_csr_wen;
  logic [LANES*XLEN-1:0] in_csr_waddr;
  logic [LANES*XLEN-1:0] in_csr_wdata;
  logic [LANES-1:0]      in_exc_wen;
  logic [LANES*XLEN-1:0] in_mcause;
  logic [LANES*XLEN-1:0] in_pc;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_kind;
  logic [XLEN-1:0]       out_a;
  logic [XLEN-1:0]       out_b;

  modport slave (
    input  in_valid, in_csr_wen, in_csr_waddr, in_csr_wdata,
           in_exc_wen, in_mcause, in_pc, out_ready,
    output in_ready, out_valid, out_kind, out_a, out_b
  );

  modport master (
    output in_valid, in_csr_wen, in_csr_waddr, in_csr_wdata,
           in_exc_wen, in_mcause, in_pc, out_ready,
    input  in_ready, out_valid, out_kind, out_a, out_b
  );
endinterface

// File: rtl/csr_commit_queue.sv
// Multi-lane commit event FIFO: packs up to two events per lane per cycle in lane
// order, drops (and counts) whatever does not fit, and serves a registered head.
module csr_commit_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  csr_commit_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);
  localparam int AW  = $clog2(DEPTH);
  localparam int NEV = 2 * LANES;
  localparam int CW  = AW + 2;

  typedef struct packed {
    logic            kind;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } ent_t;

  ent_t            mem_q [DEPTH];
  ent_t            head_q, head_d, hd;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     drop_q, drop_d;
  logic [16:0]     dsum;

  ent_t            ev      [NEV];
  logic [AW-1:0]   ev_addr [NEV];
  logic [NEV-1:0]  ev_vld, ev_acc;
  logic            pop;
  logic [CW-1:0]   free, rank, ndrop, nacc;

  // Slot 2i is lane i's CSR write, slot 2i+1 its exception: this fixes enqueue order.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign ev_vld[2*i]   = bus.in_valid[i] & bus.in_csr_wen[i];
    assign ev_vld[2*i+1] = bus.in_valid[i] & bus.in_exc_wen[i];
    assign ev[2*i]   = {1'b0, bus.in_csr_waddr[i*XLEN +: XLEN], bus.in_csr_wdata[i*XLEN +: XLEN]};
    assign ev[2*i+1] = {1'b1, bus.in_mcause[i*XLEN +: XLEN], bus.in_pc[i*XLEN +: XLEN]};
  end

  always_comb begin
    pop    = (level_q != '0) && bus.out_ready;
    free   = CW'(DEPTH) - {1'b0, level_q} + CW'(pop);
    rank   = '0;
    ndrop  = '0;
    ev_acc = '0;
    // Acceptance is a prefix of the valid events, so the running rank is the write offset.
    for (int k = 0; k < NEV; k++) begin
      ev_addr[k] = wr_ptr_q + rank[AW-1:0];
      if (ev_vld[k]) begin
        if (rank < free) ev_acc[k] = 1'b1;
        else             ndrop     = ndrop + CW'(1);
        rank = rank + CW'(1);
      end
    end
    nacc     = rank - ndrop;
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + nacc[AW-1:0];
    level_d  = level_q - (AW+1)'(pop) + nacc[AW:0];
    ovf_d    = ovf_q | (ndrop != '0);
    dsum     = {1'b0, drop_q} + 17'(ndrop);
    drop_d   = dsum[16] ? 16'hFFFF : dsum[15:0];
    // Next head comes from storage, or from this cycle's write if it lands in that slot.
    hd = mem_q[rd_ptr_d];
    for (int k = 0; k < NEV; k++) begin
      if (ev_acc[k] && (ev_addr[k] == rd_ptr_d)) hd = ev[k];
    end
    head_d = (level_d != '0) ? hd : head_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      head_q   <= head_d;
      for (int k = 0; k < NEV; k++) begin
        if (ev_acc[k]) mem_q[ev_addr[k]] <= ev[k];
      end
    end
  end

  assign bus.in_ready  = (CW'(DEPTH) - {1'b0, level_q}) >= CW'(NEV);
  assign bus.out_valid = (level_q != '0);
  assign bus.out_kind  = head_q.kind;
  assign bus.out_a     = head_q.a;
  assign bus.out_b     = head_q.b;
  assign level         = level_q;
  assign overflow      = ovf_q;
  assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_csr_commit_queue.sv
// Directed bench for csr_commit_queue (LANES=2, DEPTH=8, XLEN=32).
module tb_csr_commit_queue;
  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;
  int          checks = 0;
  int          errors = 0;

  csr_commit_queue_if #(.LANES(LANES), .XLEN(XLEN)) bus ();

  csr_commit_queue #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    bus.in_valid     = '0;
    bus.in_csr_wen   = '0;
    bus.in_exc_wen   = '0;
    bus.in_csr_waddr = '0;
    bus.in_csr_wdata = '0;
    bus.in_mcause    = '0;
    bus.in_pc        = '0;
  endtask

  task automatic set_lane(input int i, input logic cw, input logic [31:0] addr,
                          input logic [31:0] data, input logic ew,
                          input logic [31:0] cause, input logic [31:0] pc);
    bus.in_valid[i]                  = 1'b1;
    bus.in_csr_wen[i]                = cw;
    bus.in_exc_wen[i]                = ew;
    bus.in_csr_waddr[i*XLEN +: XLEN] = addr;
    bus.in_csr_wdata[i*XLEN +: XLEN] = data;
    bus.in_mcause[i*XLEN +: XLEN]    = cause;
    bus.in_pc[i*XLEN +: XLEN]        = pc;
  endtask

  // Check head against {kind,a,b}, then pop it.
  task automatic pop_chk(input string tag, input logic k, input logic [31:0] a, input logic [31:0] b);
    chk(tag, {7'd0, bus.out_valid, bus.out_kind, bus.out_a, bus.out_b}, {7'd0, 1'b1, k, a, b});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.out_ready = 1'b1;
    clr_in();
    // Inputs must be ignored while reset is low.
    set_lane(0, 1'b1, 32'h111, 32'h222, 1'b1, 32'h3, 32'h444);
    set_lane(1, 1'b1, 32'h555, 32'h666, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_level",   72'(level), 72'd0);
    chk("rst_flags",   72'({bus.out_valid, bus.in_ready, overflow}), 72'b010);
    chk("rst_drop",    72'(drop_cnt), 72'd0);
    chk("rst_head",    {7'd0, bus.out_kind, bus.out_a, bus.out_b}, 72'd0);

    reset = 1'b1;
    bus.out_ready = 1'b0;
    clr_in();
    tick();
    chk("idle_level", 72'(level), 72'd0);

    // Lane0 CSR + lane1 exception in one cycle; no same-cycle bypass.
    set_lane(0, 1'b1, 32'h300, 32'h1888, 1'b0, 32'h0, 32'h0);
    set_lane(1, 1'b0, 32'h0, 32'h0, 1'b1, 32'hB, 32'h8000_0010);
    #1;
    chk("no_bypass", 72'(bus.out_valid), 72'd0);
    tick();
    clr_in();
    chk("two_level", 72'(level), 72'd2);
    pop_chk("two_head0", 1'b0, 32'h300, 32'h1888);
    chk("two_level1", 72'(level), 72'd1);
    pop_chk("two_head1", 1'b1, 32'hB, 32'h8000_0010);
    chk("two_level0", 72'(level), 72'd0);
    chk("empty_hold", {7'd0, bus.out_valid, bus.out_kind, bus.out_a, bus.out_b},
        {7'd0, 1'b0, 1'b1, 32'hB, 32'h8000_0010});

    // One lane carrying both a CSR write and an exception.
    set_lane(1, 1'b1, 32'h341, 32'h55, 1'b1, 32'h2, 32'h100);
    tick();
    clr_in();
    pop_chk("both_csr", 1'b0, 32'h341, 32'h55);
    pop_chk("both_exc", 1'b1, 32'h2, 32'h100);
    chk("both_level", 72'(level), 72'd0);

    // Fill with out_ready=0: in_ready drops once level reaches 5.
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("fill_ready%0d", c), 72'(bus.in_ready), (c < 3) ? 72'd1 : 72'd0);
      set_lane(0, 1'b1, 32'h100 + 32'(2*c), 32'(c), 1'b0, 32'h0, 32'h0);
      set_lane(1, 1'b1, 32'h101 + 32'(2*c), 32'(c), 1'b0, 32'h0, 32'h0);
      tick();
      clr_in();
    end
    chk("full_level", 72'(level), 72'd8);
    chk("full_ready", 72'(bus.in_ready), 72'd0);
    set_lane(0, 1'b1, 32'hDEAD, 32'h1, 1'b0, 32'h0, 32'h0);
    set_lane(1, 1'b1, 32'hBEEF, 32'h2, 1'b0, 32'h0, 32'h0);
    tick();
    clr_in();
    chk("drop_cnt2",  72'(drop_cnt), 72'd2);
    chk("drop_ovf",   72'(overflow), 72'd1);
    chk("drop_level", 72'(level), 72'd8);
    chk("drop_head",  {40'd0, bus.out_a}, 72'h100);

    // Full queue with a pop: one pushed event fits in the freed slot.
    bus.out_ready = 1'b1;
    set_lane(0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h7, 32'h9000);
    tick();
    clr_in();
    bus.out_ready = 1'b0;
    chk("pp_level", 72'(level), 72'd8);
    chk("pp_drop",  72'(drop_cnt), 72'd2);
    for (int j = 0; j < 7; j++)
      pop_chk($sformatf("drain%0d", j), 1'b0, 32'h101 + 32'(j), 32'((j + 1) / 2));
    pop_chk("drain_exc", 1'b1, 32'h7, 32'h9000);
    chk("drain_level", 72'(level), 72'd0);

    // Two rounds of 6 through an 8-deep ring force pointer wrap.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        set_lane(0, 1'b1, 32'h200 + 32'(r*16 + 2*c), 32'hA0 + 32'(c), 1'b0, 32'h0, 32'h0);
        set_lane(1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h201 + 32'(r*16 + 2*c), 32'hB0 + 32'(c));
        tick();
        clr_in();
      end
      chk($sformatf("wrap_level%0d", r), 72'(level), 72'd6);
      for (int c = 0; c < 3; c++) begin
        pop_chk($sformatf("wrap%0d_csr%0d", r, c), 1'b0, 32'h200 + 32'(r*16 + 2*c), 32'hA0 + 32'(c));
        pop_chk($sformatf("wrap%0d_exc%0d", r, c), 1'b1, 32'h201 + 32'(r*16 + 2*c), 32'hB0 + 32'(c));
      end
    end
    chk("wrap_empty", 72'(bus.out_valid), 72'd0);

    // Mid-operation reset with level 5 and overflow set.
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 1'b1, 32'h600 + 32'(c), 32'h0, 1'b0, 32'h0, 32'h0);
      set_lane(1, 1'b1, 32'h610 + 32'(c), 32'h0, 1'b0, 32'h0, 32'h0);
      tick();
      clr_in();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("pre_rst_level", 72'(level), 72'd5);
    chk("pre_rst_ovf",   72'(overflow), 72'd1);
    reset = 1'b0;
    set_lane(0, 1'b1, 32'h777, 32'h1, 1'b1, 32'h1, 32'h1);
    tick();
    chk("mid_rst_level", 72'(level), 72'd0);
    chk("mid_rst_flags", 72'({bus.out_valid, bus.in_ready, overflow}), 72'b010);
    chk("mid_rst_drop",  72'(drop_cnt), 72'd0);
    chk("mid_rst_head",  {7'd0, bus.out_kind, bus.out_a, bus.out_b}, 72'd0);
    reset = 1'b1;
    clr_in();
    tick();
    chk("post_rst_level", 72'(level), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_commit_queue.md
CSR_COMMIT_QUEUE -- requirements
Module: csr_commit_queue

Interface
REQ-001 Parameter LANES, default 2: number of commit lanes per cycle.
REQ-002 Parameter DEPTH, default 8: event FIFO entries; SHALL be a power of two and at least 2*LANES.
REQ-003 Parameter XLEN, default 32: address/data width.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  LANES  per-lane commit valid.
REQ-007 in_csr_wen  in  LANES  lane commits a CSR write.
REQ-008 in_csr_waddr  in  LANES*XLEN  CSR address; lane i at bits [i*XLEN +: XLEN].
REQ-009 in_csr_wdata  in  LANES*XLEN  CSR write data.
REQ-010 in_exc_wen  in  LANES  lane commits an exception.
REQ-011 in_mcause  in  LANES*XLEN  exception cause.
REQ-012 in_pc  in  LANES*XLEN  committing PC.
REQ-013 in_ready  out  1  queue can accept a full cycle of events.
REQ-014 out_valid  out  1  head event valid.
REQ-015 out_ready  in  1  sink accepts the head event.
REQ-016 out_kind  out  1  0 = CSR write, 1 = exception.
REQ-017 out_a  out  XLEN  waddr (kind 0) or mcause (kind 1).
REQ-018 out_b  out  XLEN  wdata (kind 0) or pc (kind 1).
REQ-019 level  out  $clog2(DEPTH)+1  current occupancy.
REQ-020 overflow  out  1  sticky: at least one event dropped.
REQ-021 drop_cnt  out  16  dropped-event count, saturating at 0xFFFF.

Function
REQ-022 Event generation, per lane i: a CSR event when in_valid[i] and in_csr_wen[i]; an exception event when in_valid[i] and in_exc_wen[i]; no event when in_valid[i] is 0.
REQ-023 Cycle event count: 0..2*LANES.
REQ-024 Enqueue order within a cycle: ascending lane index; within a lane, the CSR event precedes the exception event.
REQ-025 in_ready = 1 when DEPTH - level >= 2*LANES, evaluated from registered level only, with no combinational path from in_*.
REQ-026 When in_ready = 1, all events of the cycle SHALL be written on that clock edge.
REQ-027 When in_ready = 0, events are accepted in order while free slots remain; the remaining events are dropped.
REQ-028 On any drop: overflow is set, and drop_cnt increments by the number dropped, saturating.
REQ-029 Dequeue: on out_valid && out_ready, the head entry is popped on the clock edge.
REQ-030 out_valid = (level != 0).
REQ-031 out_kind, out_a and out_b SHALL be driven from the registered head entry, with no dependence on the same-cycle inputs.
REQ-032 Simultaneous push and pop: the pop is counted first, so a slot freed this cycle is usable by this cycle's push.
REQ-033 Occupancy update: level_next = level - pop + accepted; the pointers wrap modulo DEPTH.
REQ-034 Full queue: out_valid = 1, all events are dropped unless a pop occurs that cycle, and no entry is overwritten.
REQ-035 Empty queue: out_valid = 0 and out_a/out_b hold the previous value; an event does not bypass to the output in the same cycle (minimum latency of 1 cycle from input to out_valid).
REQ-036 Dequeue order SHALL exactly match enqueue order.
REQ-037 overflow and drop_cnt clear only on reset.

Reset
REQ-038 When reset = 0 at a clock edge: level = 0, pointers = 0, out_valid = 0, in_ready = 1, overflow = 0, drop_cnt = 0, and out_kind/out_a/out_b = 0.
REQ-039 Reset asserted mid-operation discards all queued events, with no partial pop.
REQ-040 Inputs are ignored during any cycle in which reset = 0.

Verification
REQ-041 LANES=2: lane0 CSR (0x300, 0x1888) and lane1 exception (mcause 0xB, pc 0x80000010) in one cycle -> next cycle out_valid=1, kind0 a=0x300 b=0x1888; after one pop, kind1 a=0xB b=0x80000010; level goes 2 -> 1 -> 0.
REQ-042 Single lane with both csr_wen and exc_wen -> the CSR event dequeues before the exception event.
REQ-043 out_ready=0, 2 events pushed per cycle for 4 cycles (DEPTH=8) -> level=8, in_ready=0 from level 5; a fifth cycle of 2 events -> drop_cnt=2, overflow=1, contents unchanged.
REQ-044 Full queue with out_ready=1 and 1 event pushed -> event accepted, level stays 8, drop_cnt unchanged.
REQ-045 Push 6 events, pop 6, push 6 -> pointer wrap; order preserved.
REQ-046 reset=0 with level=5 and overflow=1 -> next cycle level=0, out_valid=0, overflow=0, drop_cnt=0.
